// File: rtl/memory_access.sv
// Memory stage: issues one data-memory transaction at a time, aligns/extends load
// data and drives the register-file writeback port, stalling upstream meanwhile.
module memory_access #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rd,
    input  logic            rdm_v,
    input  logic [3:0]      minst,
    input  logic [XLEN-1:0] rd_data,
    input  logic [XLEN-1:0] st_data,
    output logic            hazard_m,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_v,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_m
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [3:0] NOP  = 4'b1100;

    logic [1:0]      state;
    logic [4:0]      m_rd;
    logic            m_rdm_v;
    logic [3:0]      m_minst;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_st;

    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            misalign;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_data;

    // Loads and stores share the size encoding in minst[1:0]: 00 B, 01 H, otherwise W.
    always_comb begin
        lane     = m_addr[1:0];
        is_load  = ~m_minst[3];
        is_store = (m_minst[3:2] == 2'b10);
        is_mem   = is_load | is_store;
        misalign = 1'b0;
        be       = 4'b1111;
        wdata    = m_st;
        case (m_minst[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {(XLEN/8){m_st[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {lane[1], 1'b0};
                wdata    = {(XLEN/16){m_st[15:0]}};
                misalign = lane[0];
            end
            2'b10: misalign = (lane != 2'b00);
            default: ;
        endcase
        misalign = misalign & is_mem & (ALIGN_CHECK != 0);
    end

    always_comb begin
        byte_sel = dmem_rdata[{lane, 3'b000} +: 8];
        half_sel = dmem_rdata[{lane[1], 4'b0000} +: 16];
        case (m_minst[2:0])
            3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
            3'b010:  ld_data = dmem_rdata;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        hazard_m   = (state != IDLE) | (is_mem & ~misalign);
        dmem_req   = (state == REQ);
        dmem_we    = dmem_req & is_store;
        dmem_addr  = dmem_req ? {m_addr[XLEN-1:2], 2'b00} : '0;
        dmem_be    = dmem_req ? be : '0;
        dmem_wdata = dmem_we ? wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            m_rd    <= '0;
            m_rdm_v <= 1'b0;
            m_minst <= NOP;
            m_addr  <= '0;
            m_st    <= '0;
            wb_v    <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            exc_m   <= 1'b0;
        end else begin
            wb_v  <= 1'b0;
            exc_m <= 1'b0;
            if (!hazard_m) begin
                m_rd    <= rd;
                m_rdm_v <= rdm_v;
                m_minst <= minst;
                m_addr  <= rd_data;
                m_st    <= st_data;
            end
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wb_v <= m_rdm_v;
                        if (m_rdm_v) begin
                            wb_rd   <= m_rd;
                            wb_data <= m_addr;
                        end
                    end else if (misalign) begin
                        exc_m <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: if (dmem_ready) state <= WAIT;
                WAIT: begin
                    if (dmem_rvalid) begin
                        state <= IDLE;
                        if (is_load) begin
                            wb_v <= m_rdm_v;
                            if (m_rdm_v) begin
                                wb_rd   <= m_rd;
                                wb_data <= ld_data;
                            end
                        end
                        // Retire the latched command so IDLE does not re-issue it.
                        m_rdm_v <= 1'b0;
                        m_minst <= NOP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected writebacks are queued at issue and
// popped by an independent monitor whenever wb_v is seen.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rd;
    logic        rdm_v;
    logic [3:0]  minst;
    logic [31:0] rd_data;
    logic [31:0] st_data;
    logic        hazard_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_m;

    always #5 clk = ~clk;

    memory_access #(.XLEN(32), .ALIGN_CHECK(1)) dut (
        .clk(clk), .reset_n(reset_n), .rd(rd), .rdm_v(rdm_v), .minst(minst),
        .rd_data(rd_data), .st_data(st_data), .hazard_m(hazard_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_v(wb_v),
        .wb_rd(wb_rd), .wb_data(wb_data), .exc_m(exc_m)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && wb_v === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_v", 32'(wb_v), 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic bubble();
        rd = '0; rdm_v = 1'b0; minst = 4'b1100; rd_data = '0; st_data = '0;
    endtask

    task automatic send(input logic [4:0] r, input logic v, input logic [3:0] m,
                        input logic [31:0] d, input logic [31:0] s,
                        input bit push, input logic [31:0] exp_data);
        wb_t e;
        @(posedge clk); #1;
        rd = r; rdm_v = v; minst = m; rd_data = d; st_data = s;
        if (push) begin
            e.rd = r; e.data = exp_data;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bubble();
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (dmem_req !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_req_seen"}, 32'(dmem_req), 32'd1);
    endtask

    task automatic service(input string name, input int rdel, input int vdel, input bit stray,
                           input logic [31:0] rdata, input logic [31:0] ea,
                           input logic [3:0] ebe, input logic ewe, input logic [31:0] ewd);
        int reqs;
        chk({name, "_hazard_at_capture"}, 32'(hazard_m), 32'd1);
        wait_req(name);
        reqs = 0;
        for (int k = 0; k <= rdel; k++) begin
            dmem_ready  = (k == rdel);
            dmem_rvalid = stray && (k == rdel);
            dmem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            if (dmem_req === 1'b1) reqs++;
            if (k == rdel) begin
                chk({name, "_addr"}, dmem_addr, ea);
                chk({name, "_be"}, 32'(dmem_be), 32'(ebe));
                chk({name, "_we"}, 32'(dmem_we), 32'(ewe));
                if (ewe) chk({name, "_wdata"}, dmem_wdata, ewd);
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        chk({name, "_req_cycles"}, 32'(reqs), 32'(rdel + 1));
        for (int j = 1; j <= vdel; j++) begin
            dmem_rvalid = (j == vdel);
            dmem_rdata  = (j == vdel) ? rdata : 32'h0;
            @(negedge clk);
            if (j == vdel) begin
                chk({name, "_hazard_wait"}, 32'(hazard_m), 32'd1);
                chk({name, "_req_low_wait"}, 32'(dmem_req), 32'd0);
            end
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        chk({name, "_hazard_release"}, 32'(hazard_m), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hazard", 32'(hazard_m), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_v", 32'(wb_v), 32'd0);
        chk("rst_exc", 32'(exc_m), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ALU passthrough
        send(5'd5, 1'b1, 4'b1100, 32'h1234, 32'h0, 1'b1, 32'h1234);
        chk("alu_hazard", 32'(hazard_m), 32'd0);
        repeat (2) @(posedge clk); #1;

        // Loads: LB (with stray rvalid in acceptance cycle), LHU, LH, back-to-back LW, LBU
        send(5'd7, 1'b1, 4'b0000, 32'h103, 32'h0, 1'b1, 32'hFFFF_FF80);
        service("lb", 0, 2, 1'b1, 32'h80FF_FF7F, 32'h100, 4'b1000, 1'b0, 32'h0);
        send(5'd8, 1'b1, 4'b0101, 32'h202, 32'h0, 1'b1, 32'h0000_ABCD);
        service("lhu", 1, 1, 1'b0, 32'hABCD_0000, 32'h200, 4'b1100, 1'b0, 32'h0);
        send(5'd9, 1'b1, 4'b0001, 32'h202, 32'h0, 1'b1, 32'hFFFF_ABCD);
        service("lh", 0, 3, 1'b0, 32'hABCD_0000, 32'h200, 4'b1100, 1'b0, 32'h0);
        send(5'd10, 1'b1, 4'b0010, 32'h300, 32'h0, 1'b1, 32'h89AB_CDEF);
        service("lw", 0, 1, 1'b0, 32'h89AB_CDEF, 32'h300, 4'b1111, 1'b0, 32'h0);
        send(5'd11, 1'b1, 4'b0100, 32'h101, 32'h0, 1'b1, 32'h0000_009A);
        service("lbu", 0, 1, 1'b0, 32'h0000_9A00, 32'h100, 4'b0010, 1'b0, 32'h0);

        // Stores: no writeback expected
        send(5'd0, 1'b0, 4'b1001, 32'h6, 32'h1122_3344, 1'b0, 32'h0);
        service("sh", 3, 2, 1'b0, 32'h0, 32'h4, 4'b1100, 1'b1, 32'h3344_3344);
        send(5'd0, 1'b0, 4'b1000, 32'h9, 32'h0000_00AB, 1'b0, 32'h0);
        service("sb", 0, 1, 1'b0, 32'h0, 32'h8, 4'b0010, 1'b1, 32'hABAB_ABAB);

        // Undefined load funct3 writes back zero
        send(5'd12, 1'b1, 4'b0011, 32'h40, 32'h0, 1'b1, 32'h0);
        service("ld_undef", 0, 1, 1'b0, 32'hFFFF_FFFF, 32'h40, 4'b1111, 1'b0, 32'h0);

        // Misaligned LW
        send(5'd13, 1'b1, 4'b0010, 32'h2, 32'h0, 1'b0, 32'h0);
        chk("mis_hazard", 32'(hazard_m), 32'd0);
        chk("mis_req_a", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("mis_exc_pulse", 32'(exc_m), 32'd1);
        chk("mis_req_b", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("mis_exc_end", 32'(exc_m), 32'd0);

        // Reset during WAIT followed by a stray rvalid
        send(5'd14, 1'b1, 4'b0010, 32'h500, 32'h0, 1'b0, 32'h0);
        wait_req("rst_wait");
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("rst_wait_in_wait", 32'(hazard_m), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rst_wait_hazard", 32'(hazard_m), 32'd0);
        chk("rst_wait_req", 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("rst_stray_wb_v", 32'(wb_v), 32'd0);
        chk("rst_stray_hazard", 32'(hazard_m), 32'd0);
        send(5'd15, 1'b1, 4'b1111, 32'hCAFE, 32'h0, 1'b1, 32'hCAFE);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory (M) stage directly downstream of the execute stage.
- Consumes the execute-stage writeback/memory command (rd, rdm_v, minst, rd_data as ALU result or effective address, plus store data).
- Performs at most one data-memory transaction at a time over a valid/ready request and rvalid response bus.
- Aligns and extends load data, drives the register-file writeback port, and stalls upstream while a transaction is outstanding.

Parameters:
- XLEN, 32, data/address width.
- ALIGN_CHECK, 1, 1 = flag misaligned half/word accesses and suppress the request; 0 = pass the address through unchanged.

Ports:
- clk  in  1  stage clock.
- reset_n  in  1  synchronous active-low reset.
- rd  in  5  destination register from execute.
- rdm_v  in  1  writeback required.
- minst  in  4  memory command: 0fff = load with funct3 fff; 10ss = store, size ss (00 B, 01 H, 10 W); 11xx = no memory op.
- rd_data  in  XLEN  ALU result, or effective address when minst is a load/store.
- st_data  in  XLEN  store data (rs2).
- hazard_m  out  1  stall request to execute/fetch.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write enable.
- dmem_addr  out  XLEN  word-aligned address (addr[1:0] forced to 00).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  response valid; load data or store acknowledge.
- dmem_rdata  in  XLEN  load data.
- wb_v  out  1  register-file write strobe.
- wb_rd  out  5  write index.
- wb_data  out  XLEN  write data.
- exc_m  out  1  one-cycle misaligned-access pulse.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE.
  - hazard_m, dmem_req, wb_v, exc_m = 0.
  - wb_rd=0, wb_data=0, dmem_addr/be/wdata = 0.
- Input capture: when hazard_m=0, every clk edge latches {rd, rdm_v, minst, rd_data, st_data} into M registers. A bubble is rdm_v=0 with minst=11xx.
- States: IDLE, REQ, WAIT.
- IDLE, latched minst=11xx:
  - wb_v=rdm_v, wb_rd=rd, wb_data=rd_data, all registered.
  - Latency 1 cycle after capture; hazard_m stays 0.
- IDLE, latched load/store:
  - Misaligned if H with addr[0]=1, or W with addr[1:0]!=0 (only when ALIGN_CHECK=1).
  - Misaligned: exc_m pulses 1 cycle, no request, no writeback, remain IDLE.
  - Otherwise go to REQ with hazard_m=1 in the same cycle (combinational from the latched command).
- REQ:
  - dmem_req=1; addr, be, wdata and we held stable until dmem_ready=1.
  - On ready go to WAIT.
- WAIT:
  - dmem_req=0, hazard_m=1; hold until dmem_rvalid=1.
  - dmem_rvalid is legal no earlier than the cycle after acceptance. rvalid seen in the acceptance cycle is ignored.
  - Load on rvalid: next edge sets wb_v=rdm_v, wb_rd=rd, wb_data=extended data, and returns to IDLE.
  - Store on rvalid: return to IDLE with wb_v=0.
  - hazard_m deasserts in the cycle after rvalid, so the next instruction is captured at that edge.
- Load extraction, with a = addr[1:0]:
  - LB/LBU: byte rdata[8a+7:8a], sign/zero-extended.
  - LH/LHU: half rdata[16a[1]+15:16a[1]], sign/zero-extended.
  - LW: full word.
  - Undefined funct3 (011, 110, 111): wb_data=0, wb_v=rdm_v.
- Store lanes:
  - SB: be=0001<<a, wdata={4{st_data[7:0]}}.
  - SH: be=0011<<(2·a[1]), wdata={2{st_data[15:0]}}.
  - SW: be=1111.
- wb_v is a one-cycle strobe per instruction. wb_rd=0 never occurs with wb_v=1, since rdm_v already excludes x0.
- Reset mid-transaction: return to IDLE immediately, drop the request, and ignore any later dmem_rvalid while in IDLE.
- Back-to-back loads: second load is captured the cycle after the first writeback; no transaction overlap.

Test Plan:
- ALU passthrough: rd=5, rdm_v=1, minst=1100, rd_data=0x1234 -> next cycle wb_v=1, wb_rd=5, wb_data=0x1234, hazard_m=0.
- LB with sign extension: minst=0000, addr=0x103, rdata=0x80FF_FF7F, ready same cycle, rvalid 2 cycles later -> dmem_addr=0x100, be=1000, wb_data=0xFFFFFF80; hazard_m high from capture to the rvalid cycle.
- LHU: addr=0x202, rdata=0xABCD_0000 -> wb_data=0x0000ABCD. Repeat with LH -> 0xFFFFABCD.
- SH: addr=0x6, st_data=0x1122_3344, ready delayed 3 cycles -> dmem_req held 4 cycles, be=1100, wdata=0x3344_3344, we=1; no wb_v after rvalid.
- Misaligned LW at 0x2 -> exc_m pulse, dmem_req never asserted, wb_v=0, hazard_m=0.
- Reset during WAIT, followed by a stray rvalid -> state IDLE, wb_v stays 0, and the next ALU op writes back normally.
